// File: rtl/gpio_sequence_monitor_pkg.sv
// Shared types and defaults for the GPIO sequence monitor: FSM state encoding,
// default parameter values and the width helper for the step index.
package gpio_mon_pkg;

  localparam int DEF_WIDTH     = 34;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_TIMEOUT_W = 20;
  localparam int DEF_HEARTBEAT = 1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } mon_state_t;

  // One extra bit so the index can also hold DEPTH, the "all steps done" value.
  function automatic int step_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gpio_sequence_monitor_if.sv
// Control/status bundle between the management-side register wrapper (master)
// and the sequence monitor (slave).
interface gpio_sequence_monitor_if
  import gpio_mon_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W
) ();

  localparam int AW = $clog2(DEPTH);
  localparam int LW = step_w(DEPTH);

  logic                 load_en;
  logic [AW-1:0]        load_addr;
  logic [WIDTH-1:0]     load_data;
  logic [WIDTH-1:0]     load_mask;
  logic [LW-1:0]        seq_len;
  logic [TIMEOUT_W-1:0] timeout;
  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 pass;
  logic                 fail;
  logic [LW-1:0]        step_idx;
  logic [TIMEOUT_W-1:0] cycle_cnt;
  logic                 heartbeat;

  modport master (
    output load_en, load_addr, load_data, load_mask, seq_len, timeout, start, abort,
    input  busy, pass, fail, step_idx, cycle_cnt, heartbeat
  );

  modport slave (
    input  load_en, load_addr, load_data, load_mask, seq_len, timeout, start, abort,
    output busy, pass, fail, step_idx, cycle_cnt, heartbeat
  );

endinterface

// File: rtl/gpio_sequence_monitor_seq_mem.sv
// Sequence store: DEPTH entries of {mask, data}, one synchronous write port and
// one combinational read port. Deliberately not reset.
module gpio_mon_seq_mem
  import gpio_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] rd_mask
);

  logic [2*WIDTH-1:0] entries [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      entries[wr_addr] <= {wr_mask, wr_data};
    end
  end

  assign {rd_mask, rd_data} = entries[rd_addr];

endmodule

// File: rtl/gpio_sequence_monitor.sv
// Steps through a programmed sequence of masked io words with a per-step timeout.
// Optional heartbeat pulse is built only when GPIO_MON_HEARTBEAT_EN is defined.
module gpio_sequence_monitor
  import gpio_mon_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W,
  parameter int HEARTBEAT = DEF_HEARTBEAT
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] io_in,
  gpio_sequence_monitor_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = step_w(DEPTH);

  logic [WIDTH-1:0]     io_meta, io_s;
  mon_state_t           state, state_n;
  logic [LW-1:0]        len_q, len_n, len_clamped;
  logic [LW-1:0]        step_q, step_n;
  logic [TIMEOUT_W-1:0] to_q, to_n;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic                 pass_q, pass_n, fail_q, fail_n;
  logic [WIDTH-1:0]     exp_data, exp_mask;
  logic                 match, last_step;

  // Pads are asynchronous to clk; every compare sees only the second flop.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      io_meta <= '0;
      io_s    <= '0;
    end else begin
      io_meta <= io_in;
      io_s    <= io_meta;
    end
  end

  gpio_mon_seq_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_seq_mem (
    .clk     (clk),
    .wr_en   (bus.load_en && (state != CHECK)),
    .wr_addr (bus.load_addr),
    .wr_data (bus.load_data),
    .wr_mask (bus.load_mask),
    .rd_addr (step_q[AW-1:0]),
    .rd_data (exp_data),
    .rd_mask (exp_mask)
  );

  assign match       = ((io_s ^ exp_data) & exp_mask) == '0;
  assign last_step   = (step_q + 1'b1) == len_q;
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign len_clamped = (bus.seq_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.seq_len;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state  <= IDLE;
      len_q  <= '0;
      to_q   <= '0;
      step_q <= '0;
      cnt_q  <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      state  <= state_n;
      len_q  <= len_n;
      to_q   <= to_n;
      step_q <= step_n;
      cnt_q  <= cnt_n;
      pass_q <= pass_n;
      fail_q <= fail_n;
    end
  end

  // Abort outranks start; within CHECK a match outranks a timeout in the same cycle.
  always_comb begin
    state_n = state;
    len_n   = len_q;
    to_n    = to_q;
    step_n  = step_q;
    cnt_n   = cnt_q;
    pass_n  = pass_q;
    fail_n  = fail_q;
    if (bus.abort) begin
      state_n = IDLE;
      pass_n  = 1'b0;
      fail_n  = 1'b0;
    end else if (bus.start) begin
      len_n  = len_clamped;
      to_n   = bus.timeout;
      step_n = '0;
      cnt_n  = '0;
      fail_n = 1'b0;
      if (len_clamped == '0) begin
        state_n = PASS;
        pass_n  = 1'b1;
      end else begin
        state_n = CHECK;
        pass_n  = 1'b0;
      end
    end else begin
      case (state)
        CHECK: begin
          if (match) begin
            step_n = step_q + 1'b1;
            cnt_n  = '0;
            if (last_step) begin
              state_n = PASS;
              pass_n  = 1'b1;
            end
          end else begin
            cnt_n = cnt_inc;
            if ((to_q != '0) && (cnt_inc == to_q)) begin
              state_n = FAIL;
              fail_n  = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy      = (state == CHECK);
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.step_idx  = step_q;
  assign bus.cycle_cnt = cnt_q;

`ifdef GPIO_MON_HEARTBEAT_EN
  localparam int HB_W = $clog2(HEARTBEAT + 1);

  logic [HB_W-1:0] hb_cnt;

  // Counts busy cycles since start; holds in PASS/FAIL so the phase survives.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      hb_cnt <= '0;
    end else if (bus.abort || bus.start) begin
      hb_cnt <= '0;
    end else if (state == CHECK) begin
      hb_cnt <= (hb_cnt == HB_W'(HEARTBEAT - 1)) ? '0 : hb_cnt + 1'b1;
    end
  end

  assign bus.heartbeat = (state == CHECK) && (hb_cnt == HB_W'(HEARTBEAT - 1));
`else
  // Constant-false; the period only matters when the heartbeat is built.
  assign bus.heartbeat = (HEARTBEAT < 0);
`endif

endmodule

// File: tb/tb_gpio_sequence_monitor.sv
// Directed bench for gpio_sequence_monitor: expected status snapshots are queued
// as stimulus is applied and popped when the DUT is sampled.
module tb_gpio_sequence_monitor;
  import gpio_mon_pkg::*;

  localparam int W         = 34;
  localparam int D         = 16;
  localparam int TW        = 20;
  localparam int LW        = 5;
  localparam int HB_PERIOD = 1000;

  typedef struct {
    string          tag;
    logic           busy;
    logic           pass;
    logic           fail;
    logic [LW-1:0]  step;
    logic [TW-1:0]  cnt;
  } status_t;

  logic         clk;
  logic         nrst;
  logic [W-1:0] io_in;
  int           tests;
  int           failed;
  status_t      sb_q[$];
  int           hb_q[$];

  gpio_sequence_monitor_if #(.WIDTH(W), .DEPTH(D), .TIMEOUT_W(TW)) bus ();

  gpio_sequence_monitor #(
    .WIDTH     (W),
    .DEPTH     (D),
    .TIMEOUT_W (TW),
    .HEARTBEAT (HB_PERIOD)
  ) dut (
    .clk   (clk),
    .nrst  (nrst),
    .io_in (io_in),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_status(input string tag, input logic b, input logic p, input logic f,
                             input logic [LW-1:0] s, input logic [TW-1:0] c);
    status_t e;
    e.tag  = tag;
    e.busy = b;
    e.pass = p;
    e.fail = f;
    e.step = s;
    e.cnt  = c;
    sb_q.push_back(e);
  endtask

  task automatic check_output();
    status_t e;
    if (sb_q.size() == 0) begin
      tests++;
      failed++;
      $error("[TB] FAIL scoreboard_empty observed=0 required=1");
      return;
    end
    e = sb_q.pop_front();
    cmp({e.tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
    cmp({e.tag, ".pass"}, 32'(bus.pass), 32'(e.pass));
    cmp({e.tag, ".fail"}, 32'(bus.fail), 32'(e.fail));
    cmp({e.tag, ".step_idx"}, 32'(bus.step_idx), 32'(e.step));
    cmp({e.tag, ".cycle_cnt"}, 32'(bus.cycle_cnt), 32'(e.cnt));
  endtask

  task automatic apply_load(input int addr, input logic [W-1:0] data, input logic [W-1:0] mask);
    bus.load_en   = 1'b1;
    bus.load_addr = 4'(addr);
    bus.load_data = data;
    bus.load_mask = mask;
    tick(1);
    bus.load_en   = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [LW-1:0] len, input logic [TW-1:0] to);
    bus.seq_len = len;
    bus.timeout = to;
    bus.start   = 1'b1;
    tick(1);
    bus.start   = 1'b0;
  endtask

  initial begin
    int cyc;
    int limit;
    int exp_hb;
    tests         = 0;
    failed        = 0;
    clk           = 1'b0;
    nrst          = 1'b0;
    io_in         = {2'($urandom_range(0, 3)), 32'($urandom)};
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.load_mask = '0;
    bus.seq_len   = '0;
    bus.timeout   = '0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;

    push_status("reset", 0, 0, 0, 0, 0);
    tick(2);
    check_output();
    cmp("reset.heartbeat", 32'(bus.heartbeat), 32'd0);
    nrst  = 1'b1;
    io_in = '0;

    push_status("len0", 0, 1, 0, 0, 0);
    apply_stimulus(5'd0, 20'd50);
    check_output();
    push_status("len0_hold", 0, 1, 0, 0, 0);
    tick(1);
    check_output();

    // Length above DEPTH clamps to 16; zero masks match every cycle.
    for (int i = 0; i < D; i++) apply_load(i, {2'b0, 32'($urandom)}, '0);
    push_status("clamp_start", 1, 0, 0, 0, 0);
    apply_stimulus(5'd31, 20'd0);
    check_output();
    push_status("clamp_mid", 1, 0, 0, 15, 0);
    tick(15);
    check_output();
    push_status("clamp_done", 0, 1, 0, 16, 0);
    tick(1);
    check_output();

    apply_load(0, 34'h1, 34'hF);
    apply_load(1, 34'h3, 34'hF);
    apply_load(2, 34'h7, 34'hF);
    push_status("run_start", 1, 0, 0, 0, 0);
    apply_stimulus(5'd3, 20'd50);
    check_output();
    push_status("step0_wait", 1, 0, 0, 0, 10);
    tick(10);
    check_output();
    io_in = 34'h1;
    push_status("step0_sync", 1, 0, 0, 0, 12);
    tick(2);
    check_output();
    push_status("step0_match", 1, 0, 0, 1, 0);
    tick(1);
    check_output();
    push_status("step1_wait", 1, 0, 0, 1, 10);
    tick(10);
    check_output();
    io_in = 34'h3_0000_0003;
    push_status("step1_match", 1, 0, 0, 2, 0);
    tick(3);
    check_output();
    push_status("step2_wait", 1, 0, 0, 2, 10);
    tick(10);
    check_output();
    io_in = 34'h7;
    push_status("run_pass", 0, 1, 0, 3, 0);
    tick(3);
    check_output();

    io_in = 34'h1;
    tick(3);
    push_status("to_start", 1, 0, 0, 0, 0);
    apply_stimulus(5'd3, 20'd50);
    check_output();
    push_status("to_step0", 1, 0, 0, 1, 0);
    tick(1);
    check_output();
    push_status("to_before", 1, 0, 0, 1, 49);
    tick(49);
    check_output();
    push_status("to_fire", 0, 0, 1, 1, 50);
    tick(1);
    check_output();
    push_status("to_hold", 0, 0, 1, 1, 50);
    tick(5);
    check_output();

    // The match lands in the very cycle that would otherwise be the 50th miss.
    apply_stimulus(5'd3, 20'd50);
    tick(1);
    push_status("edge_wait", 1, 0, 0, 1, 47);
    tick(47);
    check_output();
    io_in = 34'h3;
    push_status("edge_before", 1, 0, 0, 1, 49);
    tick(2);
    check_output();
    push_status("edge_match", 1, 0, 0, 2, 0);
    tick(1);
    check_output();

    apply_load(2, 34'h3, 34'hF);
    push_status("load_ignored", 1, 0, 0, 2, 4);
    tick(3);
    check_output();
    push_status("abort", 0, 0, 0, 2, 4);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    check_output();
    push_status("start_abort", 0, 0, 0, 2, 4);
    bus.seq_len = 5'd3;
    bus.start   = 1'b1;
    bus.abort   = 1'b1;
    tick(1);
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    check_output();

    io_in = '0;
    tick(3);
`ifdef GPIO_MON_HEARTBEAT_EN
    limit = 3 * HB_PERIOD + 5;
    for (int k = 1; k <= 3; k++) hb_q.push_back(k * HB_PERIOD);
`else
    limit = HB_PERIOD + 100;
`endif
    push_status("hb_start", 1, 0, 0, 0, 0);
    apply_stimulus(5'd3, 20'd0);
    check_output();
    cyc = 1;
    repeat (limit) begin
      if (bus.heartbeat !== 1'b0) begin
        if (hb_q.size() > 0) begin
          exp_hb = hb_q.pop_front();
          cmp("hb_cycle", 32'(cyc), 32'(exp_hb));
        end else begin
          cmp("hb_spurious", 32'(cyc), 32'd0);
        end
      end
      tick(1);
      cyc++;
    end
    cmp("hb_missed", 32'(hb_q.size()), 32'd0);
    push_status("no_limit", 1, 0, 0, 0, TW'(limit));
    check_output();

    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    tick(1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
